maze_player_ctrl: RTL
=====================

Name: maze_player_ctrl

Overview:
- Produces the `move` and `win` event pulses consumed by the score/seven-segment display block.
- Converts four raw direction buttons into debounced single-step move requests.
- Checks each target cell against the maze wall ROM, tracks the player position, and flags arrival at the goal cell.
- Sits between the board buttons, the maze wall ROM and the score block.

Parameters:
- X_BITS, 4, width of the x coordinate
- Y_BITS, 4, width of the y coordinate
- GRID_W, 16, number of columns; valid x is 0..GRID_W-1
- GRID_H, 16, number of rows; valid y is 0..GRID_H-1
- START_X, 0, x position after reset
- START_Y, 0, y position after reset
- GOAL_X, 15, goal column
- GOAL_Y, 15, goal row
- DB_CYCLES, 50000, consecutive stable cycles required to accept a button level change
- DB_W, 16, debounce counter width; must satisfy 2^DB_W > DB_CYCLES

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  synchronous, active-low reset
- btn_up  input  1  raw button, asynchronous to clk, active-high; decreases y
- btn_down  input  1  raw button; increases y
- btn_left  input  1  raw button; decreases x
- btn_right  input  1  raw button; increases x
- wall_rd  output  1  wall ROM read strobe, one cycle wide
- wall_x  output  X_BITS  queried column
- wall_y  output  Y_BITS  queried row
- wall_hit  input  1  1 = queried cell is a wall; valid exactly 1 cycle after wall_rd
- pos_x  output  X_BITS  current player column
- pos_y  output  Y_BITS  current player row
- move  output  1  one-cycle pulse per accepted move, to the score block
- win  output  1  sticky goal flag, to the score block
- busy  output  1  high while a request is in flight

Behaviour:
Reset (rst==0 at a clock edge):
- pos_x=START_X, pos_y=START_Y; move=0, win=0, wall_rd=0, wall_x=0, wall_y=0, busy=0.
- All synchronizer and debounce state is cleared (debounced levels=0); FSM goes to IDLE.
- Reset applied mid-request aborts the request; no move pulse follows.

Button input path:
- Each button passes through a 2-flop synchronizer.
- Debounced level changes only after the synchronized value has differed from it for DB_CYCLES consecutive cycles. Any bounce back restarts that button's counter.
- A request is the 0->1 transition of a debounced level. A press yields exactly one request; releasing generates nothing.
- If several requests arrive in the same cycle, priority is up > down > left > right. The lower-priority requests are discarded.
- Requests arriving while not in IDLE, or while win==1, are discarded. They are not queued.

FSM states:
- IDLE: on a request, compute the target cell.
  - Target outside the grid (x-1 at 0, x+1 at GRID_W-1, y-1 at 0, y+1 at GRID_H-1): drop the request, stay in IDLE, no ROM access.
  - Otherwise latch the target and go to QUERY.
- QUERY (1 cycle): wall_rd=1, wall_x/wall_y=target, busy=1. Next state is CHECK.
- CHECK (1 cycle): sample wall_hit, busy=1.
  - wall_hit=1: go to IDLE; position unchanged, no move pulse.
  - wall_hit=0: go to COMMIT.
- COMMIT (1 cycle): pos_x/pos_y take the target value, move=1.
  - If the target equals (GOAL_X, GOAL_Y), win goes to 1 in this same cycle.
  - Next state is IDLE.

Timing and outputs:
- Latency from the debounced rising edge (cycle n, FSM in IDLE) to the move pulse: wall_rd at n+1, wall_hit sampled at n+2, move and the new position visible at n+3.
- move is registered, never high for two consecutive cycles, and low in every state other than COMMIT.
- win remains 1 until reset; the position freezes once win is set.
- wall_x/wall_y hold their last value outside QUERY.

Test Plan:
- Debounce and timing (sim with DB_CYCLES=4, start (0,0), all ROM reads return 0): hold btn_right 4+ cycles. Expect exactly one wall_rd with wall_x=1, wall_y=0; move pulses 3 cycles after the debounced edge; pos=(1,0). Holding the button longer produces no second move.
- Bounce rejection: toggle btn_down high 2 cycles, low 1 cycle, repeated 5 times, then release. Expect no wall_rd, no move, pos unchanged.
- Wall: ROM returns wall_hit=1 for (0,1); press down from (0,0). Expect wall_rd at (0,1), no move, pos stays (0,0), busy drops after CHECK.
- Edge of grid: press up at (0,0). Expect no wall_rd, no move.
- Priority: up and right become debounced in the same cycle at (0,1). Expect a query of (0,0) only; pos becomes (0,0). Right is discarded.
- Goal and reset: GOAL=(1,0); press right from (0,0). Expect move and win=1 together in one cycle; a further press yields no query. Drive rst=0 for 1 cycle: pos=(0,0), win=0, move=0. Repeat with rst=0 asserted during QUERY: expect no move pulse afterwards.

Source files
------------

// File: rtl/maze_player_ctrl.sv
// Maze player controller: debounces four direction buttons, queries the wall ROM
// for the target cell, moves the player and flags arrival at the goal cell.
module maze_player_ctrl #(
    parameter int X_BITS    = 4,
    parameter int Y_BITS    = 4,
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int GOAL_X    = 15,
    parameter int GOAL_Y    = 15,
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    output logic              wall_rd,
    output logic [X_BITS-1:0] wall_x,
    output logic [Y_BITS-1:0] wall_y,
    input  logic              wall_hit,
    output logic [X_BITS-1:0] pos_x,
    output logic [Y_BITS-1:0] pos_y,
    output logic              move,
    output logic              win,
    output logic              busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_QUERY  = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    // bit order: [0]=up [1]=down [2]=left [3]=right (also the priority order)
    logic [3:0] btn_raw;
    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    logic [3:0]      sync1_q, sync2_q, db_lvl_q, db_lvl_d, db_prev_q, req;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];

    logic [1:0]        state_q, state_d;
    logic [X_BITS-1:0] tgt_x_q, tgt_x_d, wall_x_q, wall_x_d, pos_x_q, pos_x_d, nxt_x;
    logic [Y_BITS-1:0] tgt_y_q, tgt_y_d, wall_y_q, wall_y_d, pos_y_q, pos_y_d, nxt_y;
    logic              wall_rd_q, wall_rd_d, move_q, move_d, win_q, win_d, busy_q, busy_d;
    logic              go_ok;

    // Level flips only after DB_CYCLES consecutive disagreeing cycles.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_lvl_d[i] = db_lvl_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) db_lvl_d[i] = sync2_q[i];
                else                                     db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign req = db_lvl_q & ~db_prev_q;

    always_comb begin
        state_d   = state_q;
        tgt_x_d   = tgt_x_q;
        tgt_y_d   = tgt_y_q;
        wall_rd_d = 1'b0;
        wall_x_d  = wall_x_q;
        wall_y_d  = wall_y_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        move_d    = 1'b0;
        win_d     = win_q;
        busy_d    = 1'b0;
        go_ok     = 1'b1;
        nxt_x     = pos_x_q;
        nxt_y     = pos_y_q;
        case (state_q)
            S_IDLE: begin
                if (req != 4'b0 && !win_q) begin
                    if (req[0]) begin
                        if (pos_y_q == '0) go_ok = 1'b0;
                        else               nxt_y = pos_y_q - 1'b1;
                    end else if (req[1]) begin
                        if (pos_y_q == Y_BITS'(GRID_H - 1)) go_ok = 1'b0;
                        else                                nxt_y = pos_y_q + 1'b1;
                    end else if (req[2]) begin
                        if (pos_x_q == '0) go_ok = 1'b0;
                        else               nxt_x = pos_x_q - 1'b1;
                    end else begin
                        if (pos_x_q == X_BITS'(GRID_W - 1)) go_ok = 1'b0;
                        else                                nxt_x = pos_x_q + 1'b1;
                    end
                    if (go_ok) begin
                        tgt_x_d   = nxt_x;
                        tgt_y_d   = nxt_y;
                        wall_rd_d = 1'b1;
                        wall_x_d  = nxt_x;
                        wall_y_d  = nxt_y;
                        busy_d    = 1'b1;
                        state_d   = S_QUERY;
                    end
                end
            end
            S_QUERY: begin
                busy_d  = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // wall_hit is valid here, one cycle after the ROM strobe
                if (wall_hit) begin
                    state_d = S_IDLE;
                end else begin
                    pos_x_d = tgt_x_q;
                    pos_y_d = tgt_y_q;
                    move_d  = 1'b1;
                    if (tgt_x_q == X_BITS'(GOAL_X) && tgt_y_q == Y_BITS'(GOAL_Y)) win_d = 1'b1;
                    state_d = S_COMMIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_lvl_q  <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            state_q   <= S_IDLE;
            tgt_x_q   <= '0;
            tgt_y_q   <= '0;
            wall_rd_q <= 1'b0;
            wall_x_q  <= '0;
            wall_y_q  <= '0;
            pos_x_q   <= X_BITS'(START_X);
            pos_y_q   <= Y_BITS'(START_Y);
            move_q    <= 1'b0;
            win_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q   <= state_d;
            tgt_x_q   <= tgt_x_d;
            tgt_y_q   <= tgt_y_d;
            wall_rd_q <= wall_rd_d;
            wall_x_q  <= wall_x_d;
            wall_y_q  <= wall_y_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            move_q    <= move_d;
            win_q     <= win_d;
            busy_q    <= busy_d;
        end
    end

    assign wall_rd = wall_rd_q;
    assign wall_x  = wall_x_q;
    assign wall_y  = wall_y_q;
    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign move    = move_q;
    assign win     = win_q;
    assign busy    = busy_q;
endmodule
